// File: rtl/maze_vga_renderer.sv
// maze_vga_renderer: 640x480@60 VGA scan of a 16x16 maze snapshot with
// a per-frame latched player marker; rgb/hsync/vsync share a 2-cycle pipe.
module maze_vga_renderer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int X_OFFSET  = 192,
  parameter int Y_OFFSET  = 112
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] maze_data,
  input  logic         maze_valid,
  input  logic [3:0]   player_x,
  input  logic [3:0]   player_y,
  output logic         hsync,
  output logic         vsync,
  output logic [2:0]   rgb,
  output logic         frame_start,
  output logic         snapshot_loaded
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG  = H_VISIBLE + H_FRONT;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_VISIBLE + V_FRONT;
  localparam int VS_END  = VS_BEG + V_SYNC;

  logic [9:0] h_cnt, v_cnt;
  logic       h_last, v_last;

  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  logic       active, in_maze, hs_raw, vs_raw;
  logic [3:0] cx, cy;

  assign active  = (h_cnt < 10'(H_VISIBLE)) &&
                   (v_cnt < 10'(V_VISIBLE));
  assign in_maze = (h_cnt >= 10'(X_OFFSET)) &&
                   (h_cnt <  10'(X_OFFSET + 256)) &&
                   (v_cnt >= 10'(Y_OFFSET)) &&
                   (v_cnt <  10'(Y_OFFSET + 256));
  assign cx      = 4'((h_cnt - 10'(X_OFFSET)) >> 4);
  assign cy      = 4'((v_cnt - 10'(Y_OFFSET)) >> 4);
  assign hs_raw  = !((h_cnt >= 10'(HS_BEG)) && (h_cnt < 10'(HS_END)));
  assign vs_raw  = !((v_cnt >= 10'(VS_BEG)) && (v_cnt < 10'(VS_END)));

  logic       s1_active, s1_in_maze, s1_hs, s1_vs;
  logic [3:0] s1_cx, s1_cy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_active  <= 1'b0;
      s1_in_maze <= 1'b0;
      s1_cx      <= '0;
      s1_cy      <= '0;
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
    end else begin
      s1_active  <= active;
      s1_in_maze <= in_maze;
      s1_cx      <= cx;
      s1_cy      <= cy;
      s1_hs      <= hs_raw;
      s1_vs      <= vs_raw;
    end
  end

  logic [255:0] snapshot;
  logic         mv_q, pending, mv_rise, mv_fall, load_pt;
  logic [3:0]   px_q, py_q;

  assign mv_rise = maze_valid && !mv_q;
  assign mv_fall = !maze_valid && mv_q;
  assign load_pt = (h_cnt == '0) && (v_cnt == 10'(V_VISIBLE));

  // Snapshot only changes in vertical blanking so a frame never tears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mv_q            <= 1'b0;
      pending         <= 1'b0;
      snapshot        <= '0;
      snapshot_loaded <= 1'b0;
    end else begin
      mv_q <= maze_valid;
      if (mv_fall) begin
        pending         <= 1'b0;
        snapshot_loaded <= 1'b0;
      end else if (load_pt && (pending || mv_rise)) begin
        snapshot        <= maze_data;
        pending         <= 1'b0;
        snapshot_loaded <= 1'b1;
      end else if (mv_rise) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
    end else begin
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      if (frame_start) begin
        px_q <= player_x;
        py_q <= player_y;
      end
    end
  end

  logic       cell_bit, is_player, is_origin;
  logic [2:0] colour;

  assign cell_bit  = snapshot[{s1_cy, s1_cx}];
  assign is_player = (s1_cx == px_q) && (s1_cy == py_q);
  assign is_origin = (s1_cx == 4'd0) && (s1_cy == 4'd0);

  always_comb begin
    colour = 3'b000;
    if (!s1_active || !s1_in_maze)
      colour = 3'b000;
    else if (!snapshot_loaded)
      colour = 3'b001;
    else if (is_player)
      colour = 3'b100;
    else if (cell_bit && is_origin)
      colour = 3'b010;
    else if (cell_bit)
      colour = 3'b111;
    else
      colour = 3'b001;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= 3'b000;
    end else begin
      hsync <= s1_hs;
      vsync <= s1_vs;
      rgb   <= colour;
    end
  end
endmodule

// File: tb/tb_maze_vga_renderer.sv
// tb_maze_vga_renderer: randomized maze/player stimulus checked every cycle
// against a position-based screen model, plus directed literal checks.
module tb_maze_vga_renderer;
  localparam int F = 420000;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] maze_data;
  logic         maze_valid;
  logic [3:0]   player_x, player_y;
  logic         hsync, vsync, frame_start, snapshot_loaded;
  logic [2:0]   rgb;

  maze_vga_renderer dut (
    .clk(clk), .reset(reset),
    .maze_data(maze_data), .maze_valid(maze_valid),
    .player_x(player_x), .player_y(player_y),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_start(frame_start), .snapshot_loaded(snapshot_loaded)
  );

  always #5 clk = ~clk;

  // Model: t = clock edges since reset release = scan position
  int           t;
  logic         m_loaded, m_pend, m_mvq;
  logic [255:0] m_snap;
  logic [3:0]   m_px, m_py;
  logic         m_hs, m_vs, m_fs;
  logic [2:0]   m_rgb;

  function automatic logic hs_at(int p);
    int h;
    h = (p % F) % 800;
    return !(h >= 656 && h <= 751);
  endfunction

  function automatic logic vs_at(int p);
    int v;
    v = (p % F) / 800;
    return !(v == 490 || v == 491);
  endfunction

  function automatic logic [2:0] colour_at(int p);
    int pp, h, v, cx, cy;
    pp = p % F;
    h = pp % 800;
    v = pp / 800;
    if (h >= 640 || v >= 480) return 3'b000;
    if (h < 192 || h > 447 || v < 112 || v > 367) return 3'b000;
    if (!m_loaded) return 3'b001;
    cx = (h - 192) / 16;
    cy = (v - 112) / 16;
    if (cx == int'(m_px) && cy == int'(m_py)) return 3'b100;
    if (m_snap[cx + 16 * cy])
      return (cx == 0 && cy == 0) ? 3'b010 : 3'b111;
    return 3'b001;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t <= 0;
      m_loaded <= 1'b0; m_pend <= 1'b0; m_mvq <= 1'b0;
      m_snap <= '0; m_px <= '0; m_py <= '0;
      m_hs <= 1'b1; m_vs <= 1'b1; m_fs <= 1'b0; m_rgb <= 3'b000;
    end else begin
      t     <= t + 1;
      m_fs  <= (t % F == 0);
      m_hs  <= (t == 0) ? 1'b1 : hs_at(t - 1);
      m_vs  <= (t == 0) ? 1'b1 : vs_at(t - 1);
      m_rgb <= (t == 0) ? 3'b000 : colour_at(t - 1);
      if (t % F == 1) begin
        m_px <= player_x;
        m_py <= player_y;
      end
      m_mvq <= maze_valid;
      if (m_mvq && !maze_valid) begin
        m_loaded <= 1'b0;
        m_pend   <= 1'b0;
      end else if (t % F == 480 * 800 &&
                   (m_pend || (maze_valid && !m_mvq))) begin
        m_snap   <= maze_data;
        m_pend   <= 1'b0;
        m_loaded <= 1'b1;
      end else if (maze_valid && !m_mvq) begin
        m_pend <= 1'b1;
      end
    end
  end

  int n_tests = 0;
  int n_fail = 0;
  int cyc_fail = 0;
  int hs_low = 0;
  int vs_low = 0;
  int fs_q[$];
  bit noise = 1'b0;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(string name, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, got, exp, t);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (reset) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_start) fs_q.push_back(t);
      if (cyc_fail < 20) begin
        n_tests++;
        if ({hsync, vsync, rgb, frame_start, snapshot_loaded} !==
            {m_hs, m_vs, m_rgb, m_fs, m_loaded}) begin
          n_fail++;
          cyc_fail++;
          $display("FAIL cycle t=%0d: got hs%b vs%b rgb%b fs%b ld%b, expected hs%b vs%b rgb%b fs%b ld%b",
                   t, hsync, vsync, rgb, frame_start, snapshot_loaded,
                   m_hs, m_vs, m_rgb, m_fs, m_loaded);
        end
      end
    end
    if (noise) maze_data = rand256();
  endtask

  task automatic run_until(int target);
    int guard;
    guard = 0;
    while (t < target) begin
      step();
      guard++;
      if (guard > 500000) begin
        n_fail++;
        $display("FAIL run_until timeout: t=%0d, expected to reach %0d", t, target);
        $fatal(1, "timeout");
      end
    end
  endtask

  initial begin
    logic [255:0] d;
    reset = 1'b0;
    maze_valid = 1'b0;
    maze_data = '0;
    player_x = 4'd7;
    player_y = 4'd12;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // frame 0: timing and unloaded colour
    run_until(802);
    #1 chk("hsync_low_line0", hs_low, 96);
    run_until(80102);
    chk("rgb_outside_100_100", rgb, 0);
    run_until(89794);
    chk("rgb_unloaded_192_112", rgb, 1);
    run_until(160000);
    d = '1;
    d[17] = 1'b0;
    maze_data = d;
    maze_valid = 1'b1;
    run_until(384000);
    chk("loaded_before_vblank", snapshot_loaded, 0);
    run_until(384001);
    chk("loaded_at_vblank", snapshot_loaded, 1);
    run_until(F + 1);
    #1 chk("vsync_low_frame", vs_low, 1600);
    chk("hsync_low_frame", hs_low, 525 * 96);
    run_until(F + 2);
    chk("frame_start_first", fs_q.size() > 0 ? fs_q[0] : -1, 1);
    chk("frame_start_period",
        fs_q.size() > 1 ? fs_q[1] - fs_q[0] : -1, F);

    // frame 1: loaded maze, player moved mid-frame, data noise
    noise = 1'b1;
    run_until(F + 50000);
    player_x = 4'd3;
    player_y = 4'd2;
    run_until(F + 89794);
    chk("rgb_origin_cell", rgb, 2);
    run_until(F + 102610);
    chk("rgb_wall_1_1", rgb, 1);
    run_until(F + 115442);
    chk("rgb_no_red_yet", rgb, 7);
    run_until(F + 288442);
    chk("rgb_path_15_15", rgb, 7);

    // frame 2: player marker, then carver restart
    run_until(2 * F + 115442);
    chk("rgb_player_tl", rgb, 4);
    run_until(2 * F + 115458);
    chk("rgb_right_of_player", rgb, 7);
    run_until(2 * F + 127457);
    chk("rgb_player_br", rgb, 4);
    run_until(2 * F + 128242);
    chk("rgb_below_player", rgb, 7);
    run_until(2 * F + 200000);
    noise = 1'b0;
    player_x = 4'($urandom_range(0, 15));
    player_y = 4'($urandom_range(0, 15));
    maze_valid = 1'b0;
    run_until(2 * F + 200001);
    chk("loaded_after_drop", snapshot_loaded, 0);
    run_until(2 * F + 288442);
    chk("rgb_after_drop", rgb, 1);
    run_until(2 * F + 384000);
    chk("loaded_before_reraise", snapshot_loaded, 0);
    maze_data = rand256();
    maze_valid = 1'b1;
    run_until(2 * F + 384001);
    chk("loaded_coincident", snapshot_loaded, 1);

    // frame 3: async reset inside the maze area
    run_until(3 * F + 240302);
    #2 reset = 1'b0;
    #1 chk("reset_hsync", hsync, 1);
    chk("reset_vsync", vsync, 1);
    chk("reset_rgb", rgb, 0);
    repeat (3) step();
    chk("reset_loaded", snapshot_loaded, 0);
    chk("reset_frame_start", frame_start, 0);
    reset = 1'b1;
    run_until(1);
    chk("restart_frame_start", frame_start, 1);
    chk("restart_loaded", snapshot_loaded, 0);
    run_until(2);
    chk("restart_fs_one_cycle", frame_start, 0);
    run_until(658);
    chk("restart_hsync_low", hsync, 0);
    run_until(754);
    chk("restart_hsync_high", hsync, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
